// File: rtl/queue_pkg.sv
// Shared types and helpers for the parametrised queue.
package queue_pkg;

    typedef enum logic {
        QMODE_STD  = 1'b0,
        QMODE_FWFT = 1'b1
    } qmode_e;

    // Bits needed to hold an occupancy value in 0..depth
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/param_queue_if.sv
// Producer/consumer-facing bus of param_queue.
interface param_queue_if
    import queue_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic             we;
    logic [WIDTH-1:0] in_data;
    logic             re;
    logic [WIDTH-1:0] out_data;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic [CW-1:0]    free_entries;
    logic             err_clr;
    logic             overflow;
    logic             underflow;

    modport master (
        output we, in_data, re, err_clr,
        input  out_data, empty, full, almost_empty, almost_full,
               count, free_entries, overflow, underflow
    );

    modport slave (
        input  we, in_data, re, err_clr,
        output out_data, empty, full, almost_empty, almost_full,
               count, free_entries, overflow, underflow
    );

endinterface

// File: rtl/queue_ram.sv
// WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port.
module queue_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_queue.sv
// Parametrised single-clock FIFO with STD/FWFT output, threshold flags,
// occupancy count and sticky overflow/underflow errors.
module param_queue
    import queue_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter qmode_e      MODE      = QMODE_STD,
    parameter int unsigned AF_THRESH = DEPTH - 1,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic          clk,
    input  logic          rst,
    param_queue_if.slave  bus
);

    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH);

    if (DEPTH < 2) begin : g_chk_depth
        $error("param_queue: DEPTH must be at least 2");
    end
    if (AF_THRESH > DEPTH || AE_THRESH > DEPTH) begin : g_chk_thresh
        $error("param_queue: thresholds must not exceed DEPTH");
    end

    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d, free_q, free_d;
    logic             empty_q, empty_d, full_q, full_d;
    logic             ae_q, ae_d, af_q, af_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rd_data;
    logic             wr_ok, rd_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    queue_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok && !rst),
        .waddr (wptr_q),
        .wdata (bus.in_data),
        .raddr (rptr_q),
        .rdata (rd_data)
    );

    // A write into a full queue is legal when the same edge pops the head
    always_comb begin
        wr_ok   = bus.we && (!full_q || bus.re);
        rd_ok   = bus.re && !empty_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        out_d   = out_q;

        if (wr_ok) wptr_d = next_ptr(wptr_q);
        if (rd_ok) rptr_d = next_ptr(rptr_q);

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        free_d  = CW'(DEPTH) - count_d;
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
        ae_d    = (count_d <= CW'(AE_THRESH));
        af_d    = (count_d >= CW'(AF_THRESH));
        ovf_d   = (ovf_q && !bus.err_clr) || (bus.we && !wr_ok);
        udf_d   = (udf_q && !bus.err_clr) || (bus.re && !rd_ok);

        if (MODE == QMODE_STD && rd_ok) out_d = rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            free_q  <= CW'(DEPTH);
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= (AF_THRESH == 0);
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            free_q  <= free_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ae_q    <= ae_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            out_q   <= out_d;
        end
    end

    // FWFT exposes the head directly; an empty queue shows zero, never stale RAM
    assign bus.out_data     = (MODE == QMODE_FWFT) ? (empty_q ? '0 : rd_data) : out_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.count        = count_q;
    assign bus.free_entries = free_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule
